run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
//   Parametrised successor to the lab6 one-hot consecutive-value detector.
//   Samples serial input w on enabled clock edges and flags z when w has held
//   the same value for RUN_LEN consecutive samples.
//   Per-polarity mode select, sample enable and a saturating match counter.
//   Sits between debounced switch/serial input and LED/HEX display logic.
// PARAMETERS
//   RUN_LEN  4  consecutive identical samples required for a match (>= 2)
//   CNT_W    8  width of match_cnt
//   RC_W     $clog2(RUN_LEN+1)  derived width of run_cnt; do not override
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   en         in   1      sample enable; w sampled only on edges with en=1
//   w          in   1      serial data input
//   mode       in   2      00 off, 01 runs of 1s, 10 runs of 0s, 11 both
//   clr_cnt    in   1      synchronous clear of match_cnt
//   z          out  1      registered match flag
//   run_val    out  1      value of current run (valid when state != IDLE)
//   run_cnt    out  RC_W   length of current run, saturates at RUN_LEN
//   match_cnt  out  CNT_W  number of qualifying runs reached, saturating
//   state      out  3      one-hot {RUN1,RUN0,IDLE}
// BEHAVIOUR
// - Reset (posedge clk, reset=1) has priority over all other inputs.
//   state=001 (IDLE), run_val=0, run_cnt=0, z=0, match_cnt=0.
// - en=0: all registers hold; z holds its value; clr_cnt is still honoured.
// - FSM, evaluated only on edges with en=1:
//   IDLE -> RUN{w}, run_cnt=1.
//   RUNx, w==x -> RUNx, run_cnt = min(run_cnt+1, RUN_LEN).
//   RUNx, w!=x -> RUN{w}, run_cnt=1.
//   run_val always equals x of the state entered.
// - qual = (run_val==1 & mode[0]) | (run_val==0 & mode[1]).
// - z is registered and is next-state based:
//   z <= (next run_cnt == RUN_LEN) & next qual.
//   Latency: z rises on the same edge that samples the RUN_LEN-th identical bit.
//   z stays 1 while the run continues, since run_cnt saturates (overlapping runs).
// - Mode changes take effect on the next enabled edge; they do not reset the run.
//   Example: mode 01->10 while in RUN1 at RUN_LEN drops z on the next en edge.
// - match_cnt increments once per run, on the enabled edge where run_cnt goes
//   RUN_LEN-1 -> RUN_LEN with qual true.
//   No increment during saturation, and none if mode turns qual on mid-run.
//   match_cnt saturates at 2^CNT_W-1; never wraps.
// - clr_cnt=1 clears match_cnt on that edge.
//   clr_cnt wins over a simultaneous increment; FSM and z unaffected.
// - run_cnt arithmetic in RC_W bits; must never wrap past RUN_LEN.
// - Reset mid-run discards the run; the next enabled sample starts from IDLE.
// - State encoding is one-hot; any illegal state recovers to IDLE on the
//   next enabled edge.
// TESTING (RUN_LEN=4, CNT_W=8 unless noted)
// - reset held 2 cycles, en=1 -> state=001, z=0, run_cnt=0, match_cnt=0.
// - mode=11, w=1,1,1,1,1,0 -> z=0,0,0,1,1,0; run_cnt=1,2,3,4,4,1;
//   match_cnt=1 after 4th edge.
// - mode=01, w=0 x5 -> z stays 0, match_cnt=0;
//   then w=1 x4 -> z=1 at 4th edge, match_cnt=1.
// - en toggled 1,0,1,0,... with w=1 -> only en=1 edges count;
//   z rises at 4th enabled edge; all outputs hold on en=0 edges.
// - CNT_W=2, repeat (w=1 x4, w=0 x1) 5 times with mode=01 -> match_cnt=3
//   (saturates); clr_cnt together with a match edge -> match_cnt=0.
// - reset asserted after w=1 x3 -> next w=1 x3 gives z=0, run_cnt=3;
//   4th sample gives z=1.

Source files
------------

// File: rtl/run_length_detector.sv
// run_length_detector
// Samples serial input w on enabled clock edges and raises z once w has held
// the same value for RUN_LEN consecutive samples. The polarity of runs that
// qualify is selected by mode. A saturating counter records each qualifying
// run once. The one-hot FSM tracks which value the current run holds.
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int RC_W    = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr_cnt,
  output logic             z,
  output logic             run_val,
  output logic [RC_W-1:0]  run_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state
);

  // One-hot encoding, bit order {RUN1, RUN0, IDLE}
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN0 = 3'b010,
    RUN1 = 3'b100
  } state_t;

  // Run length at which a match is declared, and the length just before it
  localparam logic [RC_W-1:0]  RUN_MAX = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0]  RUN_PRE = RC_W'(RUN_LEN - 1);
  localparam logic [RC_W-1:0]  RUN_ONE = RC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic             run_val_reg, run_val_next;
  logic [RC_W-1:0]  run_cnt_reg, run_cnt_next;
  logic             z_reg, z_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;

  // Candidate values for an enabled edge, before the enable mux
  state_t           adv_state;
  logic             adv_val;
  logic [RC_W-1:0]  adv_cnt;
  logic             adv_qual;
  logic             adv_z;
  logic             adv_hit;

  // State and data registers; reset dominates, otherwise load next values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      run_val_reg   <= 1'b0;
      run_cnt_reg   <= '0;
      z_reg         <= 1'b0;
      match_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      run_val_reg   <= run_val_next;
      run_cnt_reg   <= run_cnt_next;
      z_reg         <= z_next;
      match_cnt_reg <= match_cnt_next;
    end
  end

  // Where the FSM would go if this edge were enabled
  always_comb begin
    adv_state = IDLE;
    adv_val   = 1'b0;
    adv_cnt   = '0;
    unique case (state_reg)
      IDLE: begin
        adv_state = w ? RUN1 : RUN0;
        adv_val   = w;
        adv_cnt   = RUN_ONE;
      end
      RUN0, RUN1: begin
        adv_state = w ? RUN1 : RUN0;
        adv_val   = w;
        if (w == (state_reg == RUN1)) begin
          // Continuing run: count up but never past RUN_LEN
          adv_cnt = (run_cnt_reg >= RUN_MAX) ? RUN_MAX : run_cnt_reg + RUN_ONE;
        end else begin
          adv_cnt = RUN_ONE;
        end
      end
      default: begin
        // Corrupted (non one-hot) state: fall back to IDLE with a clean run
        adv_state = IDLE;
        adv_val   = 1'b0;
        adv_cnt   = '0;
      end
    endcase
  end

  // Match qualification is evaluated on the run being entered
  always_comb begin
    adv_qual = (adv_val & mode[0]) | (~adv_val & mode[1]);
    adv_z    = (adv_cnt == RUN_MAX) & adv_qual;
    // Count only the edge where the run first reaches RUN_LEN
    adv_hit  = (run_cnt_reg == RUN_PRE) & (adv_cnt == RUN_MAX) & adv_qual
             & (state_reg != IDLE);
  end

  // Enable mux for all registers, plus the match counter update and clear
  always_comb begin
    state_next     = state_reg;
    run_val_next   = run_val_reg;
    run_cnt_next   = run_cnt_reg;
    z_next         = z_reg;
    match_cnt_next = match_cnt_reg;
    if (en) begin
      state_next   = adv_state;
      run_val_next = adv_val;
      run_cnt_next = adv_cnt;
      z_next       = adv_z;
      if (adv_hit && (match_cnt_reg != CNT_MAX)) begin
        match_cnt_next = match_cnt_reg + 1'b1;
      end
    end
    // Clear is honoured regardless of enable and wins over an increment
    if (clr_cnt) begin
      match_cnt_next = '0;
    end
  end

  assign z         = z_reg;
  assign run_val   = run_val_reg;
  assign run_cnt   = run_cnt_reg;
  assign match_cnt = match_cnt_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: directed steps followed by random traffic,
// compared against a sample-history model. A second instance with a 2-bit
// match counter shares the same inputs to exercise counter saturation.
module tb_run_length_detector;

  localparam int RUN_LEN = 4;
  localparam int RC_W    = $clog2(RUN_LEN + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic            w = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            clr_cnt = 1'b0;

  logic            z, run_val;
  logic [RC_W-1:0] run_cnt;
  logic [7:0]      match_cnt;
  logic [2:0]      state;

  logic            z2, run_val2;
  logic [RC_W-1:0] run_cnt2;
  logic [1:0]      match_cnt2;
  logic [2:0]      state2;

  int checks = 0;
  int errors = 0;

  // Model: recent enabled samples since reset, plus z and counters
  bit hist[$];
  bit m_z;
  int m_cnt8;
  int m_cnt2;

  run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
    .z(z), .run_val(run_val), .run_cnt(run_cnt), .match_cnt(match_cnt),
    .state(state)
  );

  run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
    .z(z2), .run_val(run_val2), .run_cnt(run_cnt2), .match_cnt(match_cnt2),
    .state(state2)
  );

  always #5 clk = ~clk;

  // Number of trailing identical samples in the history
  function automatic int trail_len();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  // Model update for one clock edge with the currently driven inputs
  task automatic model_edge();
    int len;
    bit q;
    if (reset) begin
      hist.delete();
      m_z = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (en) begin
      hist.push_back(w);
      if (hist.size() > RUN_LEN + 2) void'(hist.pop_front());
      len = trail_len();
      q = (w && mode[0]) || (!w && mode[1]);
      m_z = (len >= RUN_LEN) && q;
      if (len == RUN_LEN && q) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    if (clr_cnt) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int len;
    logic [2:0] e_state;
    len = trail_len();
    if (hist.size() == 0) e_state = 3'b001;
    else if (hist[hist.size() - 1]) e_state = 3'b100;
    else e_state = 3'b010;
    chk("state", 32'(state), 32'(e_state));
    chk("run_val", 32'(run_val), (hist.size() == 0) ? 32'd0 : 32'(hist[hist.size() - 1]));
    chk("run_cnt", 32'(run_cnt), (len > RUN_LEN) ? 32'(RUN_LEN) : 32'(len));
    chk("z", 32'(z), 32'(m_z));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt8));
    chk("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
    chk("z2", 32'(z2), 32'(m_z));
    $display("t=%0t rst=%0b en=%0b w=%0b mode=%0d clr=%0b -> state=%b z=%0b run_cnt=%0d match=%0d match2=%0d",
             $time, reset, en, w, mode, clr_cnt, state, z, run_cnt, match_cnt, match_cnt2);
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, then compare shortly after it
  task automatic step(input bit e, input bit wv, input logic [1:0] m, input bit c);
    @(negedge clk);
    reset = 1'b0; en = e; w = wv; mode = m; clr_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1; en = 1'b1; w = 1'b1; clr_cnt = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    bit wv;
    logic [1:0] m;

    // Reset with enable high
    do_reset(2);

    // Both polarities: runs reach RUN_LEN then break
    step(1, 1, 2'b11, 0); step(1, 1, 2'b11, 0); step(1, 1, 2'b11, 0);
    step(1, 1, 2'b11, 0); step(1, 1, 2'b11, 0); step(1, 0, 2'b11, 0);

    // Only runs of 1s qualify
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 2'b01, 0);

    // Mode switch while saturated in RUN1 drops z without resetting the run
    step(1, 1, 2'b10, 0);
    // Mode turning qual on mid-run must not count
    step(1, 1, 2'b01, 0);

    // Enable toggling: only enabled edges advance the run
    do_reset(1);
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 1, 2'b01, 0);

    // Counter saturation on the 2-bit instance, then clear against a match
    do_reset(1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) step(1, 1, 2'b01, 0);
      step(1, 0, 2'b01, 0);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 2'b01, 0);
    step(1, 1, 2'b01, 1);
    // Clear while disabled
    step(1, 0, 2'b11, 0); step(1, 0, 2'b11, 0); step(1, 0, 2'b11, 0);
    step(1, 0, 2'b11, 0);
    step(0, 1, 2'b11, 1);

    // Reset mid-run discards the partial run
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 1, 2'b11, 0);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, 1, 2'b11, 0);

    // Random traffic with sticky w and occasional mode, clear and reset events
    wv = 1'b0;
    m = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) begin
        do_reset(1);
      end else begin
        if ($urandom_range(99) < 25) wv = ~wv;
        if ($urandom_range(99) < 5) m = 2'($urandom_range(3));
        step($urandom_range(99) < 80, wv, m, $urandom_range(99) < 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
